axilite_rr_arbiter: RTL and testbench
=====================================

Name: axilite_rr_arbiter

Overview:
Shares one AXI4-lite master port between NUM_REQ simple register-access requesters (test sequencers, config engines).
- Round-robin arbitration; one transaction outstanding at a time.
- Drives the AW/W/B/AR/R channels and returns the completion to the granted requester.
- Sits between requester logic and the m_axi_* bus that feeds the device under test or the bus responder.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width (32 only)
TIMEOUT, 256, cycles allowed per transaction before abort; 0 disables the timeout

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_we  in  NUM_REQ  1=write, 0=read
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data
req_wstrb  in  NUM_REQ*4  packed write strobes
req_ready  out  NUM_REQ  acceptance, one-hot or zero
rsp_valid  out  NUM_REQ  one-cycle completion pulse, one-hot
rsp_rdata  out  DATA_W  read data, valid with rsp_valid
rsp_resp  out  2  AXI response, valid with rsp_valid
busy  out  1  high whenever state != IDLE
m_axi_awaddr/awprot/awvalid  out  ADDR_W/3/1  write address channel; awprot=0
m_axi_awready  in  1
m_axi_wdata/wstrb/wvalid  out  DATA_W/4/1  write data channel
m_axi_wready  in  1
m_axi_bresp  in  2; m_axi_bvalid  in  1; m_axi_bready  out  1
m_axi_araddr/arprot/arvalid  out  ADDR_W/3/1  read address channel; arprot=0
m_axi_arready  in  1
m_axi_rdata  in  DATA_W; m_axi_rresp  in  2; m_axi_rvalid  in  1; m_axi_rready  out  1

Behaviour:
- Reset (async assert, sync release): state=IDLE; all m_axi_* valids/readies, req_ready, rsp_valid, busy = 0; address/data/strobe outputs = 0; rsp_rdata = 0, rsp_resp = 0; last_grant = NUM_REQ-1, so requester 0 wins first.
- Reset mid-transaction: the in-flight transaction is dropped with no rsp_valid. Bus-side cleanup is the slave's responsibility.
- States: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE, arbitration:
  - g = first i with req_valid[i], searching from last_grant+1 with wrap.
  - req_ready[g] is asserted combinationally in the same cycle (only in IDLE); a handshake occurs on that edge.
  - On the handshake: latch addr/wdata/wstrb/we of g, set last_grant=g, go to WR if we=1, else RD_ADDR.
  - No req_valid: stay in IDLE, last_grant unchanged.
- Latency: awvalid/wvalid or arvalid rise on the first cycle after acceptance.
- WR:
  - awvalid and wvalid both high on entry.
  - Each drops independently after its own valid&&ready edge and stays low.
  - When both handshakes are done (in either order, or on the same edge): go to WR_RESP.
  - Payloads are held stable while the corresponding valid is high.
- WR_RESP: bready=1. On bvalid: capture bresp, rsp_rdata=0, go to RESP. bvalid outside WR_RESP is ignored (bready=0).
- RD_ADDR: arvalid=1 until the arready edge, then go to RD_DATA.
- RD_DATA: rready=1. On rvalid: capture rdata/rresp, go to RESP.
- RESP: rsp_valid[g]=1 for exactly one cycle; rsp_rdata/rsp_resp hold until the next RESP. Next cycle: IDLE.
- Minimum request-to-request spacing per requester: 4 cycles (write with zero-wait slave).
- Timeout (TIMEOUT>0):
  - A counter is cleared on leaving IDLE and increments every cycle in WR, WR_RESP, RD_ADDR, RD_DATA.
  - When it reaches TIMEOUT: deassert all m_axi valids/readies, rsp_resp=2'b10, rsp_rdata=0, go to RESP.
  - A handshake on the same edge as the timeout wins; the counter does not wrap.
- Fairness: a requester holding req_valid continuously is served at least once every NUM_REQ transactions.

Test Plan:
- Req0 write addr 0x44A00000, data 0x4b, wstrb 0xF; zero-wait slave -> one AW and one W handshake with those values, awvalid one cycle after accept, rsp_valid[0] pulses once, rsp_resp=0, busy back low.
- Req1 read 0x44A00000; slave returns rdata 0x01234567 one cycle after arvalid -> rsp_valid[1] pulse, rsp_rdata=0x01234567, rsp_resp=0.
- Both requesters hold req_valid for 6 transactions -> grant order 0,1,0,1,0,1; never two req_ready bits high.
- awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles, exactly one handshake each, single completion.
- TIMEOUT=16, slave never asserts bvalid -> all valids low 16 cycles after leaving IDLE, rsp_resp=2'b10, rsp_rdata=0, next request still served.
- Reset pulsed while in RD_DATA -> all outputs 0 immediately, no rsp_valid; after release requester 0 is granted first.

Source files
------------

// File: rtl/axilite_rr_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ simple register requesters onto a
// single AXI4-lite master port, one transaction in flight at a time.
module axilite_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ*4-1:0]      req_wstrb,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      busy,
    output logic [ADDR_W-1:0]         m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_W-1:0]         m_axi_wdata,
    output logic [3:0]                m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [ADDR_W-1:0]         m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [DATA_W-1:0]         m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TMO_EN = (TIMEOUT > 0);
    localparam logic [TW-1:0] TMAX = TMO_EN ? TW'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [GW-1:0]      last_grant;
    logic [GW-1:0]      grant;
    logic               found;
    logic               accept;
    logic               tmo_hit;
    logic               enter_resp;
    logic [TW-1:0]      tcnt;
    logic               aw_pend;
    logic               w_pend;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [3:0]         wstrb_q;

    // Round-robin search starting just after the previous winner
    always_comb begin
        int idx;
        idx   = 0;
        grant = last_grant;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end else begin
                idx = idx;
            end
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                grant = GW'(idx);
            end else begin
                found = found;
            end
        end
    end

    assign accept  = (state == IDLE) && found;
    assign tmo_hit = TMO_EN && (tcnt == TMAX);

    // Acceptance strobe back to the winning requester, gated off under reset
    always_comb begin
        req_ready = '0;
        if (accept && !reset) begin
            req_ready[grant] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state logic; a completing handshake takes priority over the timeout
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = req_we[grant] ? WR : RD_ADDR;
                else        state_next = IDLE;
            end
            WR: begin
                if ((!aw_pend || m_axi_awready) && (!w_pend || m_axi_wready)) state_next = WR_RESP;
                else if (tmo_hit) state_next = RESP;
                else              state_next = WR;
            end
            WR_RESP: begin
                if (m_axi_bvalid)  state_next = RESP;
                else if (tmo_hit)  state_next = RESP;
                else               state_next = WR_RESP;
            end
            RD_ADDR: begin
                if (m_axi_arready) state_next = RD_DATA;
                else if (tmo_hit)  state_next = RESP;
                else               state_next = RD_ADDR;
            end
            RD_DATA: begin
                if (m_axi_rvalid)  state_next = RESP;
                else if (tmo_hit)  state_next = RESP;
                else               state_next = RD_DATA;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign enter_resp = (state_next == RESP) && (state != RESP);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Request latch, channel valids, timeout counter and completion capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= GW'(NUM_REQ - 1);
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= 4'h0;
            aw_pend    <= 1'b0;
            w_pend     <= 1'b0;
            tcnt       <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_resp   <= 2'b00;
        end else begin
            if (accept) begin
                last_grant <= grant;
                addr_q     <= req_addr[int'(grant)*ADDR_W +: ADDR_W];
                wdata_q    <= req_wdata[int'(grant)*DATA_W +: DATA_W];
                wstrb_q    <= req_wstrb[int'(grant)*4 +: 4];
                tcnt       <= '0;
            end else if (state != IDLE && state != RESP && tcnt != TMAX) begin
                tcnt <= tcnt + TW'(1);
            end else begin
                tcnt <= tcnt;
            end
            aw_pend <= (accept && req_we[grant]) ||
                       (aw_pend && !m_axi_awready && state_next == WR);
            w_pend  <= (accept && req_we[grant]) ||
                       (w_pend && !m_axi_wready && state_next == WR);
            rsp_valid <= enter_resp ? (NUM_REQ'(1) << last_grant) : '0;
            if (enter_resp) begin
                if (state == WR_RESP && m_axi_bvalid) begin
                    rsp_resp  <= m_axi_bresp;
                    rsp_rdata <= '0;
                end else if (state == RD_DATA && m_axi_rvalid) begin
                    rsp_resp  <= m_axi_rresp;
                    rsp_rdata <= m_axi_rdata;
                end else begin
                    rsp_resp  <= 2'b10;
                    rsp_rdata <= '0;
                end
            end else begin
                rsp_resp  <= rsp_resp;
                rsp_rdata <= rsp_rdata;
            end
        end
    end

    assign busy          = (state != IDLE);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = aw_pend;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = w_pend;
    assign m_axi_bready  = (state == WR_RESP);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = (state == RD_ADDR);
    assign m_axi_rready  = (state == RD_DATA);
endmodule

// File: tb/tb_axilite_rr_arbiter.sv
// Directed bench for axilite_rr_arbiter: two requesters, a configurable
// AXI4-lite responder and a negedge monitor that logs handshakes and grants.
module tb_axilite_rr_arbiter;
    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_we = '0;
    logic [NR*AW-1:0]  req_addr = '0;
    logic [NR*DW-1:0]  req_wdata = '0;
    logic [NR*4-1:0]   req_wstrb = '0;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic [1:0]        rsp_resp;
    logic              busy;
    logic [AW-1:0]     m_axi_awaddr;
    logic [2:0]        m_axi_awprot;
    logic              m_axi_awvalid;
    logic              m_axi_awready = 1'b0;
    logic [DW-1:0]     m_axi_wdata;
    logic [3:0]        m_axi_wstrb;
    logic              m_axi_wvalid;
    logic              m_axi_wready = 1'b0;
    logic [1:0]        m_axi_bresp = 2'b00;
    logic              m_axi_bvalid = 1'b0;
    logic              m_axi_bready;
    logic [AW-1:0]     m_axi_araddr;
    logic [2:0]        m_axi_arprot;
    logic              m_axi_arvalid;
    logic              m_axi_arready = 1'b0;
    logic [DW-1:0]     m_axi_rdata = '0;
    logic [1:0]        m_axi_rresp = 2'b00;
    logic              m_axi_rvalid = 1'b0;
    logic              m_axi_rready;

    axilite_rr_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder configuration (written only by the stimulus process)
    int          aw_delay = 0;
    int          w_delay = 0;
    bit          b_en = 1'b1;
    bit          r_en = 1'b1;
    logic [31:0] slave_rdata = 32'h0;

    // Cumulative monitor state (written only by the monitor process)
    int aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0;
    int aw_seen = 0, w_seen = 0;
    int aw_hi = 0, w_hi = 0, any_hi = 0, multi_ready = 0;
    int acc_cnt = 0, acc_cyc = 0, aw_rise_cyc = 0, rsp_cnt = 0, rsp_cyc = 0;
    int grant_log [0:255];
    bit aw_prev = 1'b0;
    logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0, last_rdata = '0;
    logic [3:0]  last_wstrb = '0;
    logic [2:0]  last_awprot = '0;
    logic [1:0]  last_resp = '0;
    logic [NR-1:0] last_rsp_valid = '0;

    // Responder and monitor: readies set mid-cycle apply to the next rising edge
    always @(negedge clk) begin
        m_axi_bvalid = b_en && (w_hs > b_hs) && (aw_hs > b_hs);
        m_axi_rvalid = r_en && (ar_hs > r_hs);
        m_axi_rdata  = slave_rdata;
        if (m_axi_bvalid && m_axi_bready) b_hs++;
        if (m_axi_rvalid && m_axi_rready) r_hs++;
        aw_seen = m_axi_awvalid ? aw_seen + 1 : 0;
        w_seen  = m_axi_wvalid ? w_seen + 1 : 0;
        m_axi_awready = m_axi_awvalid && (aw_seen > aw_delay);
        m_axi_wready  = m_axi_wvalid && (w_seen > w_delay);
        m_axi_arready = m_axi_arvalid;
        if (m_axi_awvalid && m_axi_awready) begin
            aw_hs++; last_awaddr = m_axi_awaddr; last_awprot = m_axi_awprot;
        end
        if (m_axi_wvalid && m_axi_wready) begin
            w_hs++; last_wdata = m_axi_wdata; last_wstrb = m_axi_wstrb;
        end
        if (m_axi_arvalid && m_axi_arready) begin
            ar_hs++; last_araddr = m_axi_araddr;
        end
        aw_hi  += int'(m_axi_awvalid);
        w_hi   += int'(m_axi_wvalid);
        any_hi += int'(m_axi_awvalid | m_axi_wvalid | m_axi_bready | m_axi_arvalid | m_axi_rready);
        if ($countones(req_ready) > 1) multi_ready++;
        if ((req_valid & req_ready) != '0) begin
            grant_log[acc_cnt & 255] = req_ready[1] ? 1 : 0;
            acc_cnt++;
            acc_cyc = cyc + 1;
        end
        if (m_axi_awvalid && !aw_prev) aw_rise_cyc = cyc;
        aw_prev = m_axi_awvalid;
        if (rsp_valid != '0) begin
            rsp_cnt++; rsp_cyc = cyc;
            last_rsp_valid = rsp_valid; last_rdata = rsp_rdata; last_resp = rsp_resp;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_txn(input int i, input bit we, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb);
        int a0, r0, n;
        a0 = acc_cnt; r0 = rsp_cnt; n = 0;
        req_we[i] = we;
        req_addr[i*AW +: AW] = addr;
        req_wdata[i*DW +: DW] = data;
        req_wstrb[i*4 +: 4] = strb;
        req_valid[i] = 1'b1;
        while (acc_cnt == a0 && n < 50) begin @(posedge clk); #1; n++; end
        req_valid[i] = 1'b0;
        while (rsp_cnt == r0 && n < 100) begin @(posedge clk); #1; n++; end
        check_eq("txn_complete", 64'(rsp_cnt != r0), 64'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    int a0, r0, b0, b1, b2, b3, b4, n;

    initial begin
        // Reset state, with a request pending that must not be accepted
        req_valid = 2'b01;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_req_ready", 64'(req_ready), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}), 64'd0);
        check_eq("rst_rsp", 64'({rsp_valid, rsp_resp}), 64'd0);
        check_eq("rst_rdata", 64'(rsp_rdata), 64'd0);
        check_eq("rst_awaddr", 64'(m_axi_awaddr), 64'd0);
        req_valid = '0;
        reset = 1'b0;
        @(posedge clk); #1;

        // Zero-wait write from requester 0
        a0 = aw_hs; b0 = w_hs; r0 = rsp_cnt;
        run_txn(0, 1'b1, 32'h44A0_0000, 32'h0000_004B, 4'hF);
        check_eq("wr_aw_hs", 64'(aw_hs - a0), 64'd1);
        check_eq("wr_w_hs", 64'(w_hs - b0), 64'd1);
        check_eq("wr_awaddr", 64'(last_awaddr), 64'h44A0_0000);
        check_eq("wr_awprot", 64'(last_awprot), 64'd0);
        check_eq("wr_wdata", 64'(last_wdata), 64'h4B);
        check_eq("wr_wstrb", 64'(last_wstrb), 64'hF);
        check_eq("wr_aw_latency", 64'(aw_rise_cyc - acc_cyc), 64'd0);
        check_eq("wr_rsp_cnt", 64'(rsp_cnt - r0), 64'd1);
        check_eq("wr_rsp_who", 64'(last_rsp_valid), 64'b01);
        check_eq("wr_rsp_resp", 64'(last_resp), 64'd0);
        check_eq("wr_rsp_latency", 64'(rsp_cyc - acc_cyc), 64'd2);
        check_eq("wr_busy_low", 64'(busy), 64'd0);

        // Write with awready delayed 3 cycles, wready immediate
        aw_delay = 3;
        a0 = aw_hs; b0 = w_hs; b1 = aw_hi; b2 = w_hi; r0 = rsp_cnt;
        run_txn(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'h3);
        check_eq("awdly_aw_hi", 64'(aw_hi - b1), 64'd4);
        check_eq("awdly_w_hi", 64'(w_hi - b2), 64'd1);
        check_eq("awdly_aw_hs", 64'(aw_hs - a0), 64'd1);
        check_eq("awdly_w_hs", 64'(w_hs - b0), 64'd1);
        check_eq("awdly_rsp_cnt", 64'(rsp_cnt - r0), 64'd1);
        check_eq("awdly_wstrb", 64'(last_wstrb), 64'h3);
        aw_delay = 0;

        // Read from requester 1
        slave_rdata = 32'h0123_4567;
        a0 = ar_hs; r0 = rsp_cnt;
        run_txn(1, 1'b0, 32'h44A0_0000, 32'h0, 4'h0);
        check_eq("rd_ar_hs", 64'(ar_hs - a0), 64'd1);
        check_eq("rd_araddr", 64'(last_araddr), 64'h44A0_0000);
        check_eq("rd_rsp_who", 64'(last_rsp_valid), 64'b10);
        check_eq("rd_rdata", 64'(last_rdata), 64'h0123_4567);
        check_eq("rd_resp", 64'(last_resp), 64'd0);
        check_eq("rd_rsp_latency", 64'(rsp_cyc - acc_cyc), 64'd2);

        // Both requesters hold req_valid: six reads alternate starting at 0
        a0 = acc_cnt; r0 = rsp_cnt; b0 = multi_ready; n = 0;
        req_we = 2'b00;
        req_addr = {32'h0000_0200, 32'h0000_0100};
        req_valid = 2'b11;
        while (acc_cnt - a0 < 6 && n < 200) begin @(posedge clk); #1; n++; end
        req_valid = 2'b00;
        while (rsp_cnt - r0 < 6 && n < 300) begin @(posedge clk); #1; n++; end
        check_eq("rr_accepts", 64'(acc_cnt - a0), 64'd6);
        check_eq("rr_rsps", 64'(rsp_cnt - r0), 64'd6);
        for (int k = 0; k < 6; k++) check_eq("rr_order", 64'(grant_log[(a0 + k) & 255]), 64'(k % 2));
        check_eq("rr_onehot", 64'(multi_ready - b0), 64'd0);
        repeat (2) @(posedge clk); #1;

        // Slave never answers B: timeout after 16 active cycles
        b_en = 1'b0;
        b0 = any_hi; r0 = rsp_cnt;
        run_txn(0, 1'b1, 32'h0000_0020, 32'h5555_AAAA, 4'hF);
        check_eq("tmo_active_cycles", 64'(any_hi - b0), 64'd16);
        check_eq("tmo_rsp_latency", 64'(rsp_cyc - acc_cyc), 64'd16);
        check_eq("tmo_resp", 64'(last_resp), 64'b10);
        check_eq("tmo_rdata", 64'(last_rdata), 64'd0);
        check_eq("tmo_rsp_who", 64'(last_rsp_valid), 64'b01);

        // Next request is still served normally
        slave_rdata = 32'hCAFE_F00D;
        run_txn(1, 1'b0, 32'h0000_0030, 32'h0, 4'h0);
        check_eq("post_tmo_rdata", 64'(last_rdata), 64'hCAFE_F00D);
        check_eq("post_tmo_resp", 64'(last_resp), 64'd0);
        check_eq("post_tmo_who", 64'(last_rsp_valid), 64'b10);

        // Reset while parked in RD_DATA
        r_en = 1'b0;
        a0 = acc_cnt; n = 0;
        req_we[1] = 1'b0;
        req_valid[1] = 1'b1;
        while (acc_cnt == a0 && n < 50) begin @(posedge clk); #1; n++; end
        req_valid[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("mid_rd_data", 64'(m_axi_rready), 64'd1);
        r0 = rsp_cnt;
        reset = 1'b1;
        #1;
        check_eq("mid_rst_busy", 64'(busy), 64'd0);
        check_eq("mid_rst_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}), 64'd0);
        check_eq("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        req_valid = 2'b11;
        #1;
        check_eq("mid_rst_req_ready", 64'(req_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("mid_rst_no_rsp", 64'(rsp_cnt - r0), 64'd0);
        r_en = 1'b1;
        a0 = acc_cnt; n = 0;
        while (acc_cnt - a0 < 2 && n < 100) begin @(posedge clk); #1; n++; end
        req_valid = 2'b00;
        while (rsp_cnt - r0 < 2 && n < 200) begin @(posedge clk); #1; n++; end
        check_eq("post_rst_first", 64'(grant_log[a0 & 255]), 64'd0);
        check_eq("post_rst_second", 64'(grant_log[(a0 + 1) & 255]), 64'd1);
        check_eq("post_rst_rsps", 64'(rsp_cnt - r0), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
